axis_dsp48_mult: RTL and testbench



---
 rtl/axis_dsp48_mult.sv | 153 +++++++++++++++
 tb/tb_axis_dsp48_mult.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_dsp48_mult.sv
// axis_dsp48_mult: 3-stage pipelined signed fixed-point multiplier on AXI-Stream.
// Per-channel TDM coefficients, selectable rounding, optional saturation with
// a sticky overflow flag, and full valid/ready back-pressure.
module axis_dsp48_mult #(
  parameter int A_WIDTH  = 24,
  parameter int B_WIDTH  = 16,
  parameter int P_WIDTH  = 24,
  parameter int SHIFT    = A_WIDTH + B_WIDTH - P_WIDTH - 1,
  parameter int CHANNELS = 1,
  parameter int SATURATE = 1
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [CHANNELS*B_WIDTH-1:0]  cfg_coef,
  input  logic [1:0]                   cfg_mode,
  input  logic [A_WIDTH-1:0]           s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [P_WIDTH-1:0]           m_axis_tdata,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready,
  output logic                         sts_overflow
);

  localparam int STAGES = 3;
  localparam int FW     = A_WIDTH + B_WIDTH;        // full product width
  localparam int TW     = FW - SHIFT;               // truncated width
  localparam int RW     = TW + 1;                   // rounded width (room for +1)
  localparam int EW     = ((RW > P_WIDTH) ? RW : P_WIDTH) + 2;  // range-check width
  localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CW-1:0]        LAST_CH = CW'(CHANNELS - 1);
  localparam logic signed [EW-1:0] MAXV = {{(EW-P_WIDTH+1){1'b0}}, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-P_WIDTH+1){1'b1}}, {(P_WIDTH-1){1'b0}}};

  // Whole pipeline freezes while the output holds an unaccepted beat.
  logic ce;
  assign ce            = ~m_axis_tvalid | m_axis_tready;
  assign s_axis_tready = ce;

  logic [STAGES:1] vld_pipe;
  assign m_axis_tvalid = vld_pipe[STAGES];

  // ---------------- channel counter / coefficient select ----------------
  logic [CW-1:0]        ch;
  logic [B_WIDTH-1:0]   coef_sel;

  generate
    if (CHANNELS == 1) begin : g_one_ch
      assign coef_sel = cfg_coef;
    end else begin : g_tdm
      assign coef_sel = cfg_coef[ch*B_WIDTH +: B_WIDTH];
    end
  endgenerate

  // Channel counter advances on every accepted input beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                   ch <= '0;
    else if (ce && s_axis_tvalid) ch <= (ch == LAST_CH) ? '0 : ch + 1'b1;
  end

  // Valid shift register, advancing only on ce.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)  vld_pipe <= '0;
    else if (ce) vld_pipe <= {vld_pipe[STAGES-1:1], s_axis_tvalid};
  end

  // ---------------- S1: sample, coefficient, mode, last ----------------
  logic [A_WIDTH-1:0] a1;
  logic [B_WIDTH-1:0] b1;
  logic [1:0]         mode1;
  logic               last1;

  // Capture the accepted beat with its per-beat configuration.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      a1 <= '0; b1 <= '0; mode1 <= '0; last1 <= 1'b0;
    end else if (ce && s_axis_tvalid) begin
      a1    <= s_axis_tdata;
      b1    <= coef_sel;
      mode1 <= cfg_mode;
      last1 <= (ch == LAST_CH);
    end
  end

  // ---------------- S2: full-precision product ----------------
  logic signed [FW-1:0] p2;
  logic [1:0]           mode2;
  logic                 last2;

  // Register the full signed product; operands sign-extended to FW.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      p2 <= '0; mode2 <= '0; last2 <= 1'b0;
    end else if (ce && vld_pipe[1]) begin
      p2    <= $signed({{B_WIDTH{a1[A_WIDTH-1]}}, a1}) *
               $signed({{A_WIDTH{b1[B_WIDTH-1]}}, b1});
      mode2 <= mode1;
      last2 <= last1;
    end
  end

  // ---------------- S3 combinational: round, range check ----------------
  logic [TW-1:0]        t;
  logic [SHIFT:0]       rx;      // remainder with a zero appended so SHIFT=1 works
  logic                 half_bit, below, inc;
  logic [RW-1:0]        rnd;
  logic signed [EW-1:0] ext;
  logic                 ovf_hi, ovf_lo;
  logic [P_WIDTH-1:0]   res;

  // T is the floor quotient; rx[SHIFT] is R>=H, the rest flags R>H when R>=H.
  always_comb begin
    t        = p2[FW-1:SHIFT];
    rx       = {p2[SHIFT-1:0], 1'b0};
    half_bit = rx[SHIFT];
    below    = |rx[SHIFT-1:0];
    case (mode2)
      2'd0:    inc = 1'b0;
      2'd1:    inc = half_bit;
      default: inc = half_bit & (below | t[0]);  // ties go to even T
    endcase
    rnd    = {t[TW-1], t} + {{TW{1'b0}}, inc};
    ext    = {{(EW-RW){rnd[RW-1]}}, rnd};
    ovf_hi = ext > MAXV;
    ovf_lo = ext < MINV;
    res    = ext[P_WIDTH-1:0];
    if (SATURATE != 0) begin
      if (ovf_hi)      res = MAXV[P_WIDTH-1:0];
      else if (ovf_lo) res = MINV[P_WIDTH-1:0];
    end
  end

  // ---------------- S3 registers: output and sticky overflow ----------------
  // Output registers; held while stalled because ce is low.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
    end else if (ce && vld_pipe[2]) begin
      m_axis_tdata <= res;
      m_axis_tlast <= last2;
    end
  end

  // Overflow flag latches on any clamped or wrapped result until reset.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                                    sts_overflow <= 1'b0;
    else if (ce && vld_pipe[2] && (ovf_hi || ovf_lo)) sts_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_axis_dsp48_mult.sv
// Directed bench for axis_dsp48_mult: rounding table, latency, overflow,
// TDM coefficients, back-pressure and mid-stream reset.
module tb_axis_dsp48_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] coef1;
  logic [63:0] coef4;
  logic [1:0]  mode;
  logic [23:0] sdata;
  logic        svalid, mready;

  logic        rdy1, rdy0, rdy4;
  logic [23:0] d1, d0, d4;
  logic        v1, v0, v4, l1, l0, l4, o1, o0, o4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Saturating single-channel instance.
  axis_dsp48_mult #(.CHANNELS(1), .SATURATE(1)) dut1 (
    .aclk(clk), .areset(rst), .cfg_coef(coef1), .cfg_mode(mode),
    .s_axis_tdata(sdata), .s_axis_tvalid(svalid), .s_axis_tready(rdy1),
    .m_axis_tdata(d1), .m_axis_tvalid(v1), .m_axis_tlast(l1),
    .m_axis_tready(mready), .sts_overflow(o1));

  // Wrapping single-channel instance.
  axis_dsp48_mult #(.CHANNELS(1), .SATURATE(0)) dut0 (
    .aclk(clk), .areset(rst), .cfg_coef(coef1), .cfg_mode(mode),
    .s_axis_tdata(sdata), .s_axis_tvalid(svalid), .s_axis_tready(rdy0),
    .m_axis_tdata(d0), .m_axis_tvalid(v0), .m_axis_tlast(l0),
    .m_axis_tready(mready), .sts_overflow(o0));

  // Four-channel TDM instance.
  axis_dsp48_mult #(.CHANNELS(4), .SATURATE(1)) dut4 (
    .aclk(clk), .areset(rst), .cfg_coef(coef4), .cfg_mode(mode),
    .s_axis_tdata(sdata), .s_axis_tvalid(svalid), .s_axis_tready(rdy4),
    .m_axis_tdata(d4), .m_axis_tvalid(v4), .m_axis_tlast(l4),
    .m_axis_tready(mready), .sts_overflow(o4));

  typedef struct packed { logic l; logic [23:0] d; } beat_t;
  beat_t q4[$];

  // Collect every beat dut4 hands off downstream.
  always @(posedge clk)
    if (v4 && mready) q4.push_back('{l: l4, d: d4});

  typedef struct { logic [1:0] mode; logic [23:0] a; logic [23:0] exp; } vec_t;
  vec_t vt[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One beat into the idle single-channel pipe; cyc counts edges until output valid.
  task automatic single(input logic [23:0] a, output int cyc);
    sdata = a; svalid = 1'b1; cyc = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      svalid = 1'b0;
      cyc++;
      if (v1) break;
    end
    if (!v1) begin
      checks++; errors++;
      $display("FAIL single_timeout: got no output valid within %0d cycles", cyc);
    end
  endtask

  // Present a beat to dut4 and hold it until accepted; valid stays up for streaming.
  task automatic send(input logic [23:0] a);
    logic acc;
    sdata = a; svalid = 1'b1; acc = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); acc = rdy4;
      @(posedge clk); #1;
      if (acc) break;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got tready low for 50 cycles, expected acceptance");
    end
  endtask

  task automatic wait_q(input int n);
    for (int k = 0; k < 40; k++) begin
      if (q4.size() >= n) break;
      @(posedge clk); #1;
    end
    chk("queue_len", q4.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [23:0] held;

    vt[0]  = '{2'd0, 24'd1,  24'd0};
    vt[1]  = '{2'd0, 24'd3,  24'd1};
    vt[2]  = '{2'd0, -24'sd1, -24'sd1};
    vt[3]  = '{2'd0, -24'sd3, -24'sd2};
    vt[4]  = '{2'd1, 24'd1,  24'd1};
    vt[5]  = '{2'd1, 24'd3,  24'd2};
    vt[6]  = '{2'd1, -24'sd1, 24'd0};
    vt[7]  = '{2'd1, -24'sd3, -24'sd1};
    vt[8]  = '{2'd2, 24'd1,  24'd0};
    vt[9]  = '{2'd2, 24'd3,  24'd2};
    vt[10] = '{2'd3, -24'sd1, 24'd0};
    vt[11] = '{2'd2, -24'sd3, -24'sd2};

    rst = 1'b1; coef1 = 16'd16384; coef4 = '0; mode = 2'd0;
    sdata = '0; svalid = 1'b0; mready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", v1, 1'b0);
    chk("rst_data",  d1, 24'd0);
    chk("rst_last",  l1, 1'b0);
    chk("rst_ovf",   o1, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Rounding table: coef 0.5 so every odd sample lands on a tie.
    for (int i = 0; i < 12; i++) begin
      mode = vt[i].mode;
      single(vt[i].a, cyc);
      if (i == 0) chk("latency", cyc, 3);
      chk($sformatf("round[%0d]", i), d1, vt[i].exp);
      chk($sformatf("tlast[%0d]", i), l1, 1'b1);
    end
    chk("no_ovf_yet", o1, 1'b0);

    // Overflow: (-2^23) * (-2^15) >> 15 = 2^23, one past max.
    coef1 = 16'h8000; mode = 2'd0;
    single(24'h800000, cyc);
    chk("sat_data",  d1, 24'h7FFFFF);
    chk("sat_ovf",   o1, 1'b1);
    chk("wrap_data", d0, 24'h800000);
    chk("wrap_ovf",  o0, 1'b1);
    @(posedge clk); #1;
    chk("ovf_sticky", o1, 1'b1);
    rst = 1'b1; #1;
    chk("ovf_clr_sat",  o1, 1'b0);
    chk("ovf_clr_wrap", o0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // TDM: 32768 * k >> 15 = k per channel.
    coef4 = {16'd4, 16'd3, 16'd2, 16'd1};
    q4.delete();
    for (int i = 0; i < 8; i++) send(24'd32768);
    svalid = 1'b0;
    wait_q(8);
    for (int i = 0; i < 8 && i < q4.size(); i++) begin
      chk($sformatf("tdm_data[%0d]", i), q4[i].d, 24'((i % 4) + 1));
      chk($sformatf("tdm_last[%0d]", i), q4[i].l, (i % 4) == 3);
    end

    // Back-pressure: ramp 2i with coef 0.5 -> i; 5-cycle stall mid-stream.
    coef4 = {4{16'd16384}};
    q4.delete();
    fork
      begin
        for (int i = 0; i < 20; i++) send(24'(2 * i));
        svalid = 1'b0;
      end
      begin
        for (int k = 0; k < 50; k++) begin
          if (q4.size() >= 4) break;
          @(posedge clk); #1;
        end
        mready = 1'b0;
        held = d4;
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          chk($sformatf("stall_rdy[%0d]", k),  rdy4, 1'b0);
          chk($sformatf("stall_vld[%0d]", k),  v4, 1'b1);
          chk($sformatf("stall_hold[%0d]", k), d4, held);
        end
        mready = 1'b1;
      end
    join
    wait_q(20);
    for (int i = 0; i < 20 && i < q4.size(); i++) begin
      chk($sformatf("ramp_data[%0d]", i), q4[i].d, 24'(i));
      chk($sformatf("ramp_last[%0d]", i), q4[i].l, (i % 4) == 3);
    end

    // Mid-stream reset: three beats parked in S1..S3 behind a stalled output.
    coef4 = {16'd4, 16'd3, 16'd2, 16'd1};
    q4.delete();
    mready = 1'b0;
    for (int i = 0; i < 3; i++) send(24'd32768);
    svalid = 1'b0;
    chk("pre_rst_valid", v4, 1'b1);
    rst = 1'b1; #1;
    chk("rst_mid_valid", v4, 1'b0);
    chk("rst_mid_data",  d4, 24'd0);
    chk("rst_mid_last",  l4, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; mready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_flushed", q4.size(), 0);
    send(24'd32768);
    svalid = 1'b0;
    wait_q(1);
    if (q4.size() > 0) begin
      chk("post_rst_ch0_data", q4[0].d, 24'd1);
      chk("post_rst_ch0_last", q4[0].l, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
